multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 32 +++
 rtl/multicycle_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_rdy;
    logic        pc_we;
    logic        ir_we;
    logic        npc_sel;
    logic [2:0]  ALUctrl;
    logic        alu_src_b;
    logic        ext_sign;
    logic        reg_we;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        mem_we;
    logic        mem_re;
    logic        illegal_op;
    logic [2:0]  state;

    modport master (
        input  instr, zero, mem_rdy,
        output pc_we, ir_we, npc_sel, ALUctrl, alu_src_b, ext_sign,
               reg_we, reg_dst, mem_to_reg, mem_we, mem_re, illegal_op, state
    );

    modport slave (
        output instr, zero, mem_rdy,
        input  pc_we, ir_we, npc_sel, ALUctrl, alu_src_b, ext_sign,
               reg_we, reg_dst, mem_to_reg, mem_we, mem_re, illegal_op, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU controller: IF/ID/EXE/MEM/WB sequencer for ADD, SUB, ORI, LW, SW, BEQ.
// Outputs are decoded combinationally from the state and the latched instruction class.
module multicycle_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        OpAdd = 3'd0,
        OpSub = 3'd1,
        OpOri = 3'd2,
        OpLw  = 3'd3,
        OpSw  = 3'd4,
        OpBeq = 3'd5,
        OpIll = 3'd6
    } op_e;

    state_e state_q, state_d;
    op_e    op_q, op_d;
    op_e    dec_op;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_instr;

    assign opcode       = bus.instr[31:26];
    assign funct        = bus.instr[5:0];
    assign unused_instr = ^bus.instr[25:6];

    // Instruction decode; only consumed while in ID.
    always_comb begin
        dec_op = OpIll;
        case (opcode)
            6'b000000: begin
                if (funct == 6'b100000) begin
                    dec_op = OpAdd;
                end else if (funct == 6'b100010) begin
                    dec_op = OpSub;
                end
            end
            6'b001101: dec_op = OpOri;
            6'b100011: dec_op = OpLw;
            6'b101011: dec_op = OpSw;
            6'b000100: dec_op = OpBeq;
            default:   dec_op = OpIll;
        endcase
    end

    // Next-state logic; the op class is captured only on the edge leaving ID.
    always_comb begin
        state_d = StIf;
        op_d    = op_q;
        case (state_q)
            StIf: state_d = StId;
            StId: begin
                op_d    = dec_op;
                state_d = (dec_op == OpIll) ? StIf : StExe;
            end
            StExe: begin
                case (op_q)
                    OpLw, OpSw:         state_d = StMem;
                    OpAdd, OpSub, OpOri: state_d = StWb;
                    default:            state_d = StIf;
                endcase
            end
            StMem: begin
                if (MEM_WAIT_EN && !bus.mem_rdy) begin
                    state_d = StMem;
                end else begin
                    state_d = (op_q == OpLw) ? StWb : StIf;
                end
            end
            StWb:    state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    // State and op-class registers; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIf;
            op_q    <= OpIll;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Control outputs; strobes are held low for the whole time rst is high.
    always_comb begin
        bus.pc_we      = 1'b0;
        bus.ir_we      = 1'b0;
        bus.npc_sel    = 1'b0;
        bus.ALUctrl    = 3'b000;
        bus.alu_src_b  = 1'b0;
        bus.ext_sign   = 1'b0;
        bus.reg_we     = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_re     = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            StIf: begin
                bus.pc_we = 1'b1;
                bus.ir_we = 1'b1;
            end
            StId: bus.illegal_op = (dec_op == OpIll);
            StExe: begin
                case (op_q)
                    OpAdd: bus.ALUctrl = 3'b001;
                    OpSub: bus.ALUctrl = 3'b011;
                    OpOri: begin
                        bus.ALUctrl   = 3'b010;
                        bus.alu_src_b = 1'b1;
                    end
                    OpLw: begin
                        bus.ALUctrl   = 3'b110;
                        bus.alu_src_b = 1'b1;
                        bus.ext_sign  = 1'b1;
                    end
                    OpSw: begin
                        bus.ALUctrl   = 3'b111;
                        bus.alu_src_b = 1'b1;
                        bus.ext_sign  = 1'b1;
                    end
                    OpBeq: begin
                        bus.ALUctrl  = 3'b101;
                        bus.ext_sign = 1'b1;
                        bus.pc_we    = bus.zero;
                        bus.npc_sel  = bus.zero;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                bus.mem_re = (op_q == OpLw);
                bus.mem_we = (op_q == OpSw);
            end
            StWb: begin
                bus.reg_we     = 1'b1;
                bus.reg_dst    = (op_q == OpAdd) || (op_q == OpSub);
                bus.mem_to_reg = (op_q == OpLw);
            end
            default: ;
        endcase
        if (rst) begin
            bus.pc_we      = 1'b0;
            bus.ir_we      = 1'b0;
            bus.reg_we     = 1'b0;
            bus.mem_we     = 1'b0;
            bus.mem_re     = 1'b0;
            bus.illegal_op = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule
